// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin front end sharing one ALU behind a one-entry registered result
//   clk        : sole clock, all state on rising edge
//   rst_n      : synchronous active-low reset
//   req_valid  : per-requester request valid (bit i = requester i)
//   req_ready  : per-requester request accepted this cycle
//   req0/req1  : {op[69:64], a[63:32], b[31:0]} per requester
//   resp_valid : per-requester result valid (only the owner's bit can be high)
//   resp_ready : per-requester result consumed
//   resp       : registered {c[33:2], over[1], zero[0]} shared by both requesters
//   ovf_count  : saturating count of drained results with over=1

module alu (
    input  logic [5:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_c,
    output logic        o_over,
    output logic        o_zero
);
    logic [31:0] w_sum;
    logic [31:0] w_dif;
    assign w_sum = i_a + i_b;
    assign w_dif = i_a - i_b;
    always_comb begin
        o_c    = '0;
        o_over = 1'b0;
        case (i_op)
            6'b100000: begin
                o_c    = w_sum;
                o_over = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
            end
            6'b100001: o_c = w_sum;
            6'b100010: begin
                o_c    = w_dif;
                o_over = (i_a[31] != i_b[31]) && (w_dif[31] != i_a[31]);
            end
            6'b100011: o_c = w_dif;
            6'b100100: o_c = i_a & i_b;
            6'b100101: o_c = i_a | i_b;
            6'b100110: o_c = i_a ^ i_b;
            6'b100111: o_c = ~(i_a | i_b);
            6'b101010: o_c = {31'd0, $signed(i_a) < $signed(i_b)};
            6'b101011: o_c = {31'd0, i_a < i_b};
            default:   ;
        endcase
    end
    assign o_zero = (o_c == '0);
endmodule

module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [69:0]      req0,
    input  logic [69:0]      req1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [33:0]      resp,
    output logic [CNT_W-1:0] ovf_count
);
    logic             r_out_valid;
    logic             r_owner;
    logic             r_last_grant;
    logic [33:0]      r_resp;
    logic [CNT_W-1:0] r_ovf_count;
    logic             w_can_issue;
    logic             w_any;
    logic             w_gnt;
    logic             w_accept;
    logic             w_drain;
    logic [69:0]      w_alu_req;
    logic [33:0]      w_alu_ans;

    // the output slot frees up in the same cycle its held result is consumed
    assign w_can_issue = ~r_out_valid | resp_ready[r_owner];
    assign w_any       = |req_valid;
    // on a tie the requester that did not win last time gets the grant
    assign w_gnt       = &req_valid ? ~r_last_grant : req_valid[1];
    assign w_accept    = rst_n & w_any & w_can_issue;
    assign w_drain     = rst_n & r_out_valid & resp_ready[r_owner];
    assign req_ready   = w_accept ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
    assign resp_valid  = (rst_n & r_out_valid) ? (r_owner ? 2'b10 : 2'b01) : 2'b00;
    assign w_alu_req   = ~w_any ? '0 : (w_gnt ? req1 : req0);
    assign resp        = r_resp;
    assign ovf_count   = r_ovf_count;

    alu u_alu (
        .i_op   (w_alu_req[69:64]),
        .i_a    (w_alu_req[63:32]),
        .i_b    (w_alu_req[31:0]),
        .o_c    (w_alu_ans[33:2]),
        .o_over (w_alu_ans[1]),
        .o_zero (w_alu_ans[0])
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_owner      <= 1'b0;
            r_resp       <= '0;
            r_ovf_count  <= '0;
            r_last_grant <= 1'b1;
        end else begin
            if (w_accept) begin
                r_resp       <= w_alu_ans;
                r_owner      <= w_gnt;
                r_last_grant <= w_gnt;
                r_out_valid  <= 1'b1;
            end else if (w_drain) begin
                r_out_valid <= 1'b0;
            end
            if (w_drain && r_resp[1] && !(&r_ovf_count))
                r_ovf_count <= r_ovf_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed scoreboard bench for alu_arbiter
module tb_alu_arbiter;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_ready;
    logic [69:0]   req0 = '0;
    logic [69:0]   req1 = '0;
    logic [1:0]    resp_valid;
    logic [1:0]    resp_ready = 2'b00;
    logic [33:0]   resp;
    logic [CW-1:0] ovf_count;

    int          n_chk = 0;
    int          n_err = 0;
    logic [34:0] sb[$];
    logic        m_held = 1'b0;
    logic        m_owner = 1'b0;
    logic        m_last = 1'b1;
    logic        m_over = 1'b0;
    int          m_ovf = 0;
    logic [1:0]  e_rdy;
    logic        w;
    logic [33:0] ea;
    logic [1:0]  acc;
    logic [1:0]  v;
    logic [69:0] q0;
    logic [69:0] q1;
    logic [5:0]  ops [0:11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F, 6'h00};

    alu_arbiter #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0       (req0),
        .req1       (req1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp       (resp),
        .ovf_count  (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [69:0] mk(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        return {op, a, b};
    endfunction

    // ALU semantics from plain integer arithmetic: signed overflow is a 64-bit result out of 32-bit range
    function automatic logic [33:0] ref_alu(input logic [69:0] r);
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        longint      s;
        logic        ov;
        op = r[69:64];
        a  = r[63:32];
        b  = r[31:0];
        c  = '0;
        ov = 1'b0;
        s  = 0;
        case (op)
            6'h20: begin
                s  = longint'($signed(a)) + longint'($signed(b));
                c  = a + b;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            6'h21: c = a + b;
            6'h22: begin
                s  = longint'($signed(a)) - longint'($signed(b));
                c  = a - b;
                ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            6'h23: c = a - b;
            6'h24: c = a & b;
            6'h25: c = a | b;
            6'h26: c = a ^ b;
            6'h27: c = ~(a | b);
            6'h2A: c = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2B: c = (a < b) ? 32'd1 : 32'd0;
            default: c = '0;
        endcase
        return {c, ov, c == 32'd0};
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [69:0] rnd_req();
        return {ops[$urandom_range(0, 11)], rnd_opnd(), rnd_opnd()};
    endfunction

    task automatic apply(input logic rst, input logic [1:0] vv, input logic [69:0] a0,
                         input logic [69:0] a1, input logic [1:0] rr, output logic [1:0] ac);
        rst_n      = rst;
        req_valid  = vv;
        req0       = a0;
        req1       = a1;
        resp_ready = rr;
        @(negedge clk);
        ac = req_valid & req_ready;
        @(posedge clk);
        #1;
    endtask

    // reference model: predicts handshakes and enqueues the expected result at acceptance
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_ovf_count", 64'(ovf_count), 64'(m_ovf));
            m_held  = 1'b0;
            m_owner = 1'b0;
            m_last  = 1'b1;
            m_ovf   = 0;
            sb.delete();
        end else begin
            e_rdy = 2'b00;
            w     = 1'b0;
            if ((!m_held || resp_ready[m_owner]) && req_valid != 2'b00) begin
                w        = (req_valid == 2'b11) ? ~m_last : req_valid[1];
                e_rdy[w] = 1'b1;
            end
            chk("req_ready", 64'(req_ready), 64'(e_rdy));
            chk("resp_valid", 64'(resp_valid), m_held ? 64'(2'b01 << m_owner) : 64'd0);
            chk("ovf_count", 64'(ovf_count), 64'(m_ovf));
            if (m_held && resp_ready[m_owner]) begin
                if (m_over && m_ovf < (2 ** CW) - 1) m_ovf++;
                m_held = 1'b0;
            end
            if (e_rdy != 2'b00) begin
                ea = ref_alu(w ? req1 : req0);
                sb.push_back({w, ea});
                m_held  = 1'b1;
                m_owner = w;
                m_last  = w;
                m_over  = ea[1];
            end
        end
    end

    // monitor: every cycle a result is presented it must match the oldest outstanding expectation
    initial forever begin
        @(negedge clk);
        if (resp_valid != 2'b00) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                chk("resp_owner", 64'(resp_valid), 64'(2'b01 << sb[0][34]));
                chk("resp", 64'(resp), 64'(sb[0][33:0]));
                if ((resp_valid & resp_ready) != 2'b00) void'(sb.pop_front());
            end
        end
    end

    initial begin
        repeat (3) apply(1'b0, 2'b00, '0, '0, 2'b00, acc);
        apply(1'b1, 2'b01, mk(6'h21, 32'd5, 32'd7), '0, 2'b11, acc);
        apply(1'b1, 2'b00, '0, '0, 2'b11, acc);
        repeat (4) apply(1'b1, 2'b11, mk(6'h21, 32'd5, 32'd1), mk(6'h23, 32'd10, 32'd3), 2'b11, acc);
        apply(1'b1, 2'b00, '0, '0, 2'b11, acc);
        apply(1'b1, 2'b10, '0, mk(6'h20, 32'h7FFF_FFFF, 32'd1), 2'b00, acc);
        apply(1'b1, 2'b00, '0, '0, 2'b00, acc);
        apply(1'b1, 2'b00, '0, '0, 2'b10, acc);
        apply(1'b1, 2'b00, '0, '0, 2'b11, acc);
        apply(1'b1, 2'b01, mk(6'h24, 32'hF0F0, 32'hFF00), '0, 2'b00, acc);
        repeat (3) apply(1'b1, 2'b11, mk(6'h25, 32'd1, 32'd2), mk(6'h26, 32'd3, 32'd5), 2'b00, acc);
        apply(1'b1, 2'b11, mk(6'h25, 32'd1, 32'd2), mk(6'h26, 32'd3, 32'd5), 2'b01, acc);
        apply(1'b1, 2'b00, '0, '0, 2'b11, acc);
        apply(1'b1, 2'b01, mk(6'h22, 32'd3, 32'd3), '0, 2'b11, acc);
        apply(1'b1, 2'b01, mk(6'h3F, 32'd9, 32'd9), '0, 2'b11, acc);
        apply(1'b1, 2'b00, '0, '0, 2'b11, acc);
        apply(1'b1, 2'b10, '0, mk(6'h21, 32'd1, 32'd1), 2'b00, acc);
        apply(1'b1, 2'b00, '0, '0, 2'b00, acc);
        apply(1'b0, 2'b11, mk(6'h21, 32'd2, 32'd2), mk(6'h21, 32'd4, 32'd4), 2'b00, acc);
        apply(1'b1, 2'b11, mk(6'h21, 32'd2, 32'd2), mk(6'h21, 32'd4, 32'd4), 2'b11, acc);
        apply(1'b1, 2'b00, '0, '0, 2'b11, acc);
        repeat (5) apply(1'b1, 2'b01, mk(6'h20, 32'h7FFF_FFFF, 32'h7FFF_FFFF), '0, 2'b11, acc);
        repeat (2) apply(1'b1, 2'b00, '0, '0, 2'b11, acc);
        v  = 2'b00;
        q0 = rnd_req();
        q1 = rnd_req();
        repeat (600) begin
            if (!v[0] && $urandom_range(0, 2) != 0) begin
                v[0] = 1'b1;
                q0   = rnd_req();
            end
            if (!v[1] && $urandom_range(0, 2) != 0) begin
                v[1] = 1'b1;
                q1   = rnd_req();
            end
            apply($urandom_range(0, 79) != 0, v, q0, q1, 2'($urandom_range(0, 3)), acc);
            v = v & ~acc;
        end
        repeat (3) apply(1'b1, 2'b00, '0, '0, 2'b11, acc);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the overflow event counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low; one clock domain, no asynchronous reset path.
REQ-004 SHALL have port req_valid  input  2  per-requester request valid (bit i = requester i).
REQ-005 SHALL have port req_ready  output  2  per-requester request accepted this cycle.
REQ-006 SHALL have port req0  input  alu_req_t (70: op 6, a 32, b 32)  requester 0 operation.
REQ-007 SHALL have port req1  input  alu_req_t (70)  requester 1 operation.
REQ-008 SHALL have port resp_valid  output  2  per-requester result valid.
REQ-009 SHALL have port resp_ready  input  2  per-requester result consumed.
REQ-010 SHALL have port resp  output  alu_ans_t (34: c 32, over 1, zero 1)  registered result, shared by both requesters.
REQ-011 SHALL have port ovf_count  output  CNT_W  saturating count of delivered results with over=1.

Function
REQ-012 SHALL contain exactly one alu instance; its inputs are driven from the granted requester's port, or all-zero when no grant.
REQ-013 SHALL hold a one-entry output register {resp, owner, out_valid}; resp_valid[owner]=out_valid; resp_valid[~owner]=0.
REQ-014 SHALL define can_issue = ~out_valid | resp_ready[owner]; request may be accepted in the same cycle the held result drains.
REQ-015 SHALL arbitrate round-robin: grant goes to the sole valid requester; if both valid, grant goes to the requester not in last_grant.
REQ-016 SHALL assert req_ready[i] only when i is granted and can_issue=1; at most one bit of req_ready high per cycle.
REQ-017 SHALL update last_grant only on an accepted request (req_valid[i] & req_ready[i]).
REQ-018 SHALL, on acceptance in cycle N, load the alu output and owner=i into the output register; resp_valid[i]=1 in cycle N+1 (latency 1).
REQ-019 SHALL, when out_valid and resp_ready[owner]=0, hold resp and owner stable and deassert both req_ready bits.
REQ-020 SHALL clear out_valid on resp_ready[owner]=1 with no new acceptance; on simultaneous drain and acceptance, out_valid stays 1 with new contents.
REQ-021 SHALL ignore resp_ready[~owner] and resp_ready while out_valid=0.
REQ-022 SHALL increment ovf_count by 1 when a result with over=1 is drained (resp_valid & resp_ready); holds at all-ones (saturate, no wrap).
REQ-023 SHALL pass alu results unmodified: c, over, zero as produced for op/a/b; unsupported op yields c=0, zero=1, over=0.
REQ-024 SHALL make requester inputs don't-care unless req_valid is high; requester must hold req stable until req_ready.
REQ-025 SHALL support back-to-back throughput of one result per cycle when resp_ready[owner] stays high.

Reset
REQ-026 SHALL, when rst_n=0 at a clock edge, set out_valid=0, owner=0, resp=0, ovf_count=0, last_grant=1 (requester 0 wins first tie).
REQ-027 SHALL keep req_ready=0 and resp_valid=0 during any cycle rst_n=0 is sampled low; a held result mid-handshake is discarded.
REQ-028 SHALL deliver no result for a request presented in a reset cycle; first acceptance possible in first cycle after rst_n=1.

Verification
REQ-029 SHALL be verified: after reset, req0 {op=100001, a=5, b=7} only, resp_ready=11 -> req_ready=01 cycle N, resp_valid=01, c=12, zero=0 at N+1.
REQ-030 SHALL be verified: both valid each cycle, resp_ready=11 -> grants alternate 0,1,0,1; resp owner alternates; one result per cycle.
REQ-031 SHALL be verified: req1 {op=100000, a=0x7FFFFFFF, b=1} then drain -> c=0x80000000, over=1, ovf_count 0->1 on drain cycle.
REQ-032 SHALL be verified: result held with resp_ready=00 for 3 cycles, both req_valid high -> req_ready=00, resp stable all 3 cycles; resp_ready[owner]=1 -> drain and next grant same cycle.
REQ-033 SHALL be verified: req0 {op=100010, a=3, b=3} -> c=0, zero=1, over=0; op=111111 -> c=0, zero=1.
REQ-034 SHALL be verified: rst_n low while resp_valid=10 -> next cycle resp_valid=00, ovf_count=0; tie after release grants requester 0.
